// File: rtl/gbc_video_pkg.sv
// Shared GBC video geometry, capture FSM encoding and pixel colour expansion
// for the LCD sampler and the frame-buffer path.
package gbc_video_pkg;

    localparam int H_PIXELS        = 160;
    localparam int V_LINES         = 144;
    localparam int VRAM_SIZE       = H_PIXELS * V_LINES;
    localparam int VRAM_ADDR_WIDTH = 15;

    typedef enum logic [0:0] {
        WAIT_SPS = 1'b0,
        ACTIVE   = 1'b1
    } capture_state_t;

    // Replicate each 1-bit channel so full-on maps to full-scale RRRGGGBB.
    function automatic logic [7:0] expand_rgb(input logic [2:0] pixel);
        return {{3{pixel[2]}}, {3{pixel[1]}}, {2{pixel[0]}}};
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for one asynchronous level, followed by a history
// flop so rising/falling edges can be detected in the sample-clock domain.
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~hist_q;
    assign fall  = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/gbc_lcd_sampler.sv
// Oversamples the GBC LCD bus on the 100 MHz clock and turns each DCLK falling
// edge into a single-cycle write into the 160x144 frame buffer.
module gbc_lcd_sampler #(
    parameter int H_PIXELS    = gbc_video_pkg::H_PIXELS,
    parameter int V_LINES     = gbc_video_pkg::V_LINES,
    parameter int ADDR_WIDTH  = gbc_video_pkg::VRAM_ADDR_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLK_100MHz,
    input  logic                  RESET,
    input  logic                  GBC_DCLK,
    input  logic                  GBC_CLS,
    input  logic                  GBC_SPS,
    input  logic [2:0]            GBC_PIXEL_DATA,
    output logic [ADDR_WIDTH-1:0] VRAM_WRITE_ADDR,
    output logic [7:0]            VRAM_WRITE_DATA,
    output logic                  VRAM_WRITE_EN,
    output logic                  FRAME_START,
    output logic                  LINE_ERR,
    output logic                  FRAME_ERR
);

    import gbc_video_pkg::*;

    localparam int COL_W = $clog2(H_PIXELS + 1);
    localparam int ROW_W = $clog2(V_LINES + 1);
    localparam logic [COL_W-1:0]      COL_MAX     = COL_W'(H_PIXELS);
    localparam logic [ROW_W-1:0]      ROW_MAX     = ROW_W'(V_LINES);
    localparam logic [ADDR_WIDTH-1:0] LINE_STRIDE = ADDR_WIDTH'(H_PIXELS);
    localparam logic [COL_W-1:0]      COL_ONE     = COL_W'(1);
    localparam logic [ROW_W-1:0]      ROW_ONE     = ROW_W'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE    = ADDR_WIDTH'(1);

    logic dclk_fall, cls_rise, sps_fall;
    logic dclk_level_unused, dclk_rise_unused;
    logic cls_level_unused, cls_fall_unused;
    logic sps_level_unused, sps_rise_unused;

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_dclk_sync (
        .clk      (CLK_100MHz),
        .rst      (RESET),
        .async_in (GBC_DCLK),
        .level    (dclk_level_unused),
        .rise     (dclk_rise_unused),
        .fall     (dclk_fall)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_cls_sync (
        .clk      (CLK_100MHz),
        .rst      (RESET),
        .async_in (GBC_CLS),
        .level    (cls_level_unused),
        .rise     (cls_rise),
        .fall     (cls_fall_unused)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sps_sync (
        .clk      (CLK_100MHz),
        .rst      (RESET),
        .async_in (GBC_SPS),
        .level    (sps_level_unused),
        .rise     (sps_rise_unused),
        .fall     (sps_fall)
    );

    // Data uses the same depth as the control synchronizers, so its last
    // stage lines up with the cycle in which the DCLK fall is detected.
    logic [SYNC_STAGES-1:0][2:0] pix_sync_q;
    logic                        ev_dclk_fall_q, ev_cls_rise_q, ev_sps_fall_q;
    logic [2:0]                  ev_pixel_q;

    always_ff @(posedge CLK_100MHz or posedge RESET) begin
        if (RESET) begin
            pix_sync_q     <= '0;
            ev_dclk_fall_q <= 1'b0;
            ev_cls_rise_q  <= 1'b0;
            ev_sps_fall_q  <= 1'b0;
            ev_pixel_q     <= '0;
        end else begin
            pix_sync_q     <= {pix_sync_q[SYNC_STAGES-2:0], GBC_PIXEL_DATA};
            ev_dclk_fall_q <= dclk_fall;
            ev_cls_rise_q  <= cls_rise;
            ev_sps_fall_q  <= sps_fall;
            ev_pixel_q     <= pix_sync_q[SYNC_STAGES-1];
        end
    end

    capture_state_t          state_q, state_n;
    logic [COL_W-1:0]        col_q, col_n;
    logic [ROW_W-1:0]        row_q, row_n;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_n;
    logic [ADDR_WIDTH-1:0]   row_base_q, row_base_n;
    logic                    wr_en_q, wr_en_n;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_n;
    logic [7:0]              wr_data_q, wr_data_n;
    logic                    frame_start_q, frame_start_n;
    logic                    line_err_q, line_err_n;
    logic                    frame_err_q, frame_err_n;

    always_ff @(posedge CLK_100MHz or posedge RESET) begin
        if (RESET) begin
            state_q       <= WAIT_SPS;
            col_q         <= '0;
            row_q         <= '0;
            addr_q        <= '0;
            row_base_q    <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            frame_start_q <= 1'b0;
            line_err_q    <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_n;
            col_q         <= col_n;
            row_q         <= row_n;
            addr_q        <= addr_n;
            row_base_q    <= row_base_n;
            wr_en_q       <= wr_en_n;
            wr_addr_q     <= wr_addr_n;
            wr_data_q     <= wr_data_n;
            frame_start_q <= frame_start_n;
            line_err_q    <= line_err_n;
            frame_err_q   <= frame_err_n;
        end
    end

    // SPS overrides everything else in its cycle; within a line the pixel
    // write uses the old position before a coincident CLS advances the row.
    always_comb begin
        state_n       = state_q;
        col_n         = col_q;
        row_n         = row_q;
        addr_n        = addr_q;
        row_base_n    = row_base_q;
        wr_en_n       = 1'b0;
        wr_addr_n     = wr_addr_q;
        wr_data_n     = wr_data_q;
        frame_start_n = 1'b0;
        line_err_n    = line_err_q;
        frame_err_n   = frame_err_q;

        if (ev_sps_fall_q) begin
            if (state_q == ACTIVE && row_q != ROW_MAX) begin
                frame_err_n = 1'b1;
            end
            frame_start_n = 1'b1;
            col_n         = '0;
            row_n         = '0;
            addr_n        = '0;
            row_base_n    = '0;
            state_n       = ACTIVE;
        end else if (state_q == ACTIVE) begin
            if (ev_dclk_fall_q && row_q < ROW_MAX) begin
                if (col_q < COL_MAX) begin
                    wr_en_n   = 1'b1;
                    wr_addr_n = addr_q;
                    wr_data_n = expand_rgb(ev_pixel_q);
                    col_n     = col_q + COL_ONE;
                    addr_n    = addr_q + ADDR_ONE;
                end else begin
                    line_err_n = 1'b1;
                end
            end
            // row_base tracks row*H_PIXELS incrementally, avoiding a multiplier.
            if (ev_cls_rise_q) begin
                col_n = '0;
                if (row_q < ROW_MAX) begin
                    row_n      = row_q + ROW_ONE;
                    row_base_n = row_base_q + LINE_STRIDE;
                    addr_n     = row_base_q + LINE_STRIDE;
                end
            end
        end
    end

    assign VRAM_WRITE_EN   = wr_en_q;
    assign VRAM_WRITE_ADDR = wr_addr_q;
    assign VRAM_WRITE_DATA = wr_data_q;
    assign FRAME_START     = frame_start_q;
    assign LINE_ERR        = line_err_q;
    assign FRAME_ERR       = frame_err_q;

endmodule

// File: tb/tb_gbc_lcd_sampler.sv
// Directed bench for gbc_lcd_sampler: a behavioural model of the LCD capture
// rules queues expected writes, and a negedge monitor pops and compares them.
module tb_gbc_lcd_sampler;

    localparam int H = 160;
    localparam int V = 144;

    logic        clk;
    logic        rst;
    logic        gbc_dclk, gbc_cls, gbc_sps;
    logic [2:0]  gbc_data;
    logic [14:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_en, frame_start, line_err, frame_err;

    gbc_lcd_sampler dut (
        .CLK_100MHz      (clk),
        .RESET           (rst),
        .GBC_DCLK        (gbc_dclk),
        .GBC_CLS         (gbc_cls),
        .GBC_SPS         (gbc_sps),
        .GBC_PIXEL_DATA  (gbc_data),
        .VRAM_WRITE_ADDR (wr_addr),
        .VRAM_WRITE_DATA (wr_data),
        .VRAM_WRITE_EN   (wr_en),
        .FRAME_START     (frame_start),
        .LINE_ERR        (line_err),
        .FRAME_ERR       (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [14:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t         exp_q[$];
    int          tests_run = 0;
    int          tests_failed = 0;
    int          writes_seen = 0;
    int          frame_starts_seen = 0;
    logic [14:0] last_addr_seen = '0;

    bit m_active = 1'b0;
    int m_col = 0;
    int m_row = 0;
    bit m_line_err = 1'b0;
    bit m_frame_err = 1'b0;
    int m_frame_starts = 0;

    function automatic logic [7:0] rgb_expected(input logic [2:0] d);
        return {d[2], d[2], d[2], d[1], d[1], d[1], d[0], d[0]};
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (frame_start === 1'b1) frame_starts_seen++;
        if (wr_en === 1'b1) begin
            writes_seen++;
            check_output("write_was_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output("write_addr", wr_addr, e.addr);
                check_output("write_data", wr_data, e.data);
            end
            last_addr_seen = wr_addr;
        end
    end

    task automatic model_pixel(input logic [2:0] d);
        wr_t w;
        if (m_active && m_row < V) begin
            if (m_col >= H) begin
                m_line_err = 1'b1;
            end else begin
                w.addr = 15'(m_row * H + m_col);
                w.data = rgb_expected(d);
                exp_q.push_back(w);
                m_col++;
            end
        end
    endtask

    task automatic model_cls();
        if (m_active) begin
            m_col = 0;
            if (m_row < V) m_row++;
        end
    endtask

    task automatic model_sps();
        if (m_active && m_row != V) m_frame_err = 1'b1;
        m_active = 1'b1;
        m_col = 0;
        m_row = 0;
        m_frame_starts++;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic apply_pixel(input logic [2:0] d);
        gbc_dclk = 1'b1;
        gbc_data = d;
        cycles(4);
        gbc_dclk = 1'b0;
        model_pixel(d);
        cycles(4);
    endtask

    task automatic apply_cls();
        gbc_cls = 1'b1;
        model_cls();
        cycles(4);
        gbc_cls = 1'b0;
        cycles(4);
    endtask

    task automatic apply_sps();
        gbc_sps = 1'b0;
        model_sps();
        cycles(4);
        gbc_sps = 1'b1;
        cycles(4);
    endtask

    task automatic apply_pixel_cls(input logic [2:0] d);
        gbc_dclk = 1'b1;
        gbc_data = d;
        cycles(4);
        gbc_dclk = 1'b0;
        gbc_cls  = 1'b1;
        model_pixel(d);
        model_cls();
        cycles(4);
        gbc_cls = 1'b0;
        cycles(4);
    endtask

    task automatic apply_pixel_sps(input logic [2:0] d);
        gbc_dclk = 1'b1;
        gbc_data = d;
        cycles(4);
        gbc_dclk = 1'b0;
        gbc_sps  = 1'b0;
        model_sps();
        cycles(4);
        gbc_sps = 1'b1;
        cycles(4);
    endtask

    task automatic check_state(input string tag);
        cycles(2);
        check_output({tag, "_queue_drained"}, exp_q.size(), 0);
        check_output({tag, "_line_err"}, line_err, m_line_err);
        check_output({tag, "_frame_err"}, frame_err, m_frame_err);
        check_output({tag, "_frame_starts"}, frame_starts_seen, m_frame_starts);
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_en"}, wr_en, 0);
        check_output({tag, "_addr"}, wr_addr, 0);
        check_output({tag, "_data"}, wr_data, 0);
        check_output({tag, "_frame_start"}, frame_start, 0);
        check_output({tag, "_line_err"}, line_err, 0);
        check_output({tag, "_frame_err"}, frame_err, 0);
    endtask

    initial begin
        int writes_before;
        rst      = 1'b1;
        gbc_dclk = 1'b0;
        gbc_cls  = 1'b0;
        gbc_sps  = 1'b1;
        gbc_data = 3'b000;
        cycles(3);
        check_all_zero("reset");
        rst = 1'b0;
        cycles(2);

        // DCLK and CLS activity before any SPS must be ignored.
        for (int i = 0; i < 10; i++) apply_pixel(3'(i));
        apply_cls();
        check_state("no_sps");
        check_output("no_sps_writes", writes_seen, 0);

        // Frame 1: full first and last lines, short lines in between.
        apply_sps();
        for (int c = 0; c < H; c++) apply_pixel(3'b101);
        apply_cls();
        for (int r = 1; r < V - 1; r++) begin
            apply_pixel(3'(r));
            apply_pixel(3'(r + 3));
            apply_cls();
        end
        for (int c = 0; c < H; c++) apply_pixel(3'(c));
        apply_cls();
        apply_pixel(3'b111);
        apply_cls();
        check_state("frame1");
        check_output("frame1_last_addr", last_addr_seen, 23039);
        check_output("frame1_writes", writes_seen, 2 * H + (V - 2) * 2);
        apply_sps();
        check_state("frame1_end");
        check_output("frame1_end_frame_err", frame_err, 0);
        check_output("frame1_end_frame_starts", frame_starts_seen, 2);

        // Frame 2: coincident DCLK fall and CLS rise at row 3, col 5.
        repeat (3) apply_cls();
        for (int c = 0; c < 5; c++) apply_pixel(3'(c));
        apply_pixel_cls(3'b011);
        apply_pixel(3'b110);
        check_state("coincident");
        check_output("coincident_next_addr", last_addr_seen, 640);
        repeat (96) apply_cls();
        apply_sps();
        check_state("short_frame");
        check_output("short_frame_err", frame_err, 1);

        // Frame 3: an overlong line.
        for (int c = 0; c < H + 5; c++) apply_pixel(3'(c + 1));
        check_state("long_line");
        check_output("long_line_err", line_err, 1);
        check_output("long_line_last_addr", last_addr_seen, 159);
        apply_sps();
        check_state("long_line_sticky");
        check_output("line_err_after_sps", line_err, 1);

        // Reset mid-line at row 10, col 50.
        repeat (10) apply_cls();
        for (int c = 0; c < 50; c++) apply_pixel(3'(c));
        check_state("pre_reset");
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        m_active    = 1'b0;
        m_col       = 0;
        m_row       = 0;
        m_line_err  = 1'b0;
        m_frame_err = 1'b0;
        cycles(2);
        rst = 1'b0;
        cycles(2);
        writes_before = writes_seen;
        for (int i = 0; i < 5; i++) apply_pixel(3'(i));
        apply_cls();
        check_state("after_reset");
        check_output("after_reset_no_writes", writes_seen, writes_before);
        apply_pixel_sps(3'b010);
        check_output("sps_beats_dclk", writes_seen, writes_before);

        gbc_dclk = 1'b1;
        gbc_data = 3'b110;
        cycles(4);
        gbc_dclk = 1'b0;
        model_pixel(3'b110);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("latency_early", wr_en, 0);
        @(posedge clk);
        @(negedge clk);
        check_output("latency_on_time", wr_en, 1);
        check_output("first_addr_after_reset", wr_addr, 0);
        check_output("first_data_after_reset", wr_data, 8'hFC);
        @(posedge clk);
        @(negedge clk);
        check_output("en_single_cycle", wr_en, 0);
        cycles(2);
        apply_pixel(3'b001);
        check_state("final");
        check_output("final_addr", last_addr_seen, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
